i2c_slave: RTL
==============

// Module: i2c_slave
// PURPOSE
//  I2C target (responder) answering the bridge's I2C master on the same bus.
//  Samples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit
//  address, ACKs, and moves 32-bit words: writes land on Dout, reads send Din.
//  SDA is open-drain (sda_oe=1 pulls low); the target never drives SCL (no stretching).
// PARAMETERS
//  SLAVE_ADDR  7'b1100101  7-bit bus address this target answers to
//  NBYTES      4           bytes per word, 4 max (fixed width of Din/Dout)
// PORTS
//  CLK         in   1   system clock, >= 8x SCL frequency
//  RST         in   1   synchronous, active-high reset
//  i2c_scl     in   1   bus SCL (pad input)
//  i2c_sda_in  in   1   bus SDA (pad input)
//  i2c_sda_oe  out  1   1 = pull SDA low, 0 = release
//  Din         in   32  read data, latched when a read is address-ACKed
//  Dout        out  32  write data, byte-shifted in MSB first
//  wr_valid    out  1   1-CLK pulse when NBYTES written bytes complete a word
//  rd_req      out  1   1-CLK pulse when Din is latched (upstream may advance)
//  i2c_stat    out  8   [0] busy [1] r/w [2] master NACK [3] addr match [5:4] byte cnt [7:6] 0
// BEHAVIOUR
//  - Reset: i2c_sda_oe=0, Dout=0, wr_valid=0, rd_req=0, i2c_stat=0, state IDLE.
//  - Input path: SCL and SDA each pass through a 2-FF synchronizer, then a third FF
//    for edge detection. Bus events are seen 3 CLK after the pin changes.
//  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
//    Both take priority over everything except RST and are honoured in every state.
//  - Data is sampled on the SCL rising edge. i2c_sda_oe changes 1 CLK after the
//    SCL falling edge is detected.
//  - States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
//    - IDLE: on START, go to ADDR; bit_cnt=0; byte_cnt=0.
//    - ADDR: shift in 8 bits MSB first (7 address bits, then R/W).
//      - On match: go to ADDR_ACK after the 8th SCL falling edge, set stat[3] and stat[1].
//      - On mismatch: go to IDLE with SDA released; wait for the next START.
//    - ADDR_ACK: hold sda_oe=1 for the 9th clock; release on its falling edge.
//      - W: go to WR_DATA.
//      - R: latch Din into the tx shifter, pulse rd_req, go to RD_DATA.
//    - WR_DATA: on the 8th bit, Dout <= {Dout[23:0], byte}; byte_cnt++; go to WR_ACK.
//      When byte_cnt wraps from NBYTES-1 to 0, pulse wr_valid.
//    - WR_ACK: drive sda_oe=1 for the 9th clock, then return to WR_DATA.
//    - RD_DATA: present tx[31] on each SCL falling edge (sda_oe = ~bit), shift left;
//      release SDA after the 8th bit; go to RD_ACK.
//    - RD_ACK: sample the master's bit on the SCL rise.
//      - ACK(0): byte_cnt++, go to RD_DATA. On wrap, reload Din and pulse rd_req.
//      - NACK(1): set stat[2], release SDA, go to IDLE and wait for STOP/START.
//  - Repeated START in any state: go to ADDR. bit_cnt and byte_cnt clear; Dout is kept.
//  - STOP in any state: go to IDLE, sda_oe=0. A partial byte is discarded and Dout is
//    unchanged. stat[0] clears; stat[2:1] hold until the next START.
//  - stat[0] is 1 from address match until STOP, START-mismatch or NACK.
//  - RST mid-transfer: sda_oe=0 on the next CLK edge, state IDLE. The block ignores
//    the bus until a fresh START.
// TESTING
//  1. START, 0xCA (0x65 W), bytes 00 00 FE AB, STOP -> 5 ACKs, Dout=32'h0000FEAB,
//     one wr_valid pulse after byte 4, stat[0]=0 after STOP.
//  2. Din=32'h0000FEAB; START, 0xCB (R); master ACKs 3 bytes, NACKs the 4th ->
//     SDA carries 00 00 FE AB, rd_req pulses once, stat[2]=1, sda_oe=0 after NACK.
//  3. START, 0xC8 (addr 0x64) W, one byte -> sda_oe stays 0 throughout,
//     Dout unchanged, stat=0.
//  4. Write byte 0x12, repeated START, 0xCB read -> ACK, Dout=32'h00000012,
//     read begins at Din[31:24].
//  5. RST high for 1 CLK during bit 3 of a read byte -> sda_oe=0 next CLK.
//     Subsequent SCL pulses get no response until a START.
//  6. STOP after 5 bits of a write byte -> IDLE, Dout unchanged, wr_valid never pulses.

Source files
------------

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: 7-bit address match, 32-bit word writes to Dout, reads from Din.
// SCL/SDA are oversampled by CLK; the target only ever pulls SDA low and never stretches SCL.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1100101,
  parameter int unsigned NBYTES     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i2c_scl,
  input  logic        i2c_sda_in,
  output logic        i2c_sda_oe,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        wr_valid,
  output logic        rd_req,
  output logic [7:0]  i2c_stat
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_e;

  localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

  state_e      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] dout_q, dout_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic        rd_req_q, rd_req_d;
  logic        busy_q, busy_d;
  logic        stat_rw_q, stat_rw_d;
  logic        stat_nack_q, stat_nack_d;
  logic        stat_match_q, stat_match_d;
  logic        ack_hi_q, ack_hi_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  // Index 1 is the synchronized level; index 2 is one CLK older for edge detection.
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_s & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  = scl_s & ~sda_sync_q[2] & sda_sync_q[1];

  always_comb begin
    state_d      = state_q;
    scl_sync_d   = {scl_sync_q[1:0], i2c_scl};
    sda_sync_d   = {sda_sync_q[1:0], i2c_sda_in};
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    dout_d       = dout_q;
    sda_oe_d     = sda_oe_q;
    wr_valid_d   = 1'b0;
    rd_req_d     = 1'b0;
    busy_d       = busy_q;
    stat_rw_d    = stat_rw_q;
    stat_nack_d  = stat_nack_q;
    stat_match_d = stat_match_q;
    ack_hi_d     = ack_hi_q;

    if (start_det) begin
      state_d      = ADDR;
      bit_cnt_d    = 4'd0;
      byte_cnt_d   = 2'd0;
      sda_oe_d     = 1'b0;
      stat_rw_d    = 1'b0;
      stat_nack_d  = 1'b0;
      stat_match_d = 1'b0;
      ack_hi_d     = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (rx_q[7:1] == SLAVE_ADDR) begin
              state_d      = ADDR_ACK;
              sda_oe_d     = 1'b1;
              stat_match_d = 1'b1;
              stat_rw_d    = rx_q[0];
              busy_d       = 1'b1;
              ack_hi_d     = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        // The ACK falling edge is also the first data-change point of a read,
        // so the MSB of the latched word goes out here.
        ADDR_ACK: begin
          if (scl_rise) begin
            ack_hi_d = 1'b1;
          end else if (scl_fall && ack_hi_q) begin
            ack_hi_d = 1'b0;
            if (stat_rw_q) begin
              tx_d      = {Din[30:0], 1'b0};
              sda_oe_d  = ~Din[31];
              rd_req_d  = 1'b1;
              bit_cnt_d = 4'd1;
              state_d   = RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            dout_d     = {dout_q[23:0], rx_q};
            byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? 2'd0 : byte_cnt_q + 2'd1;
            wr_valid_d = (byte_cnt_q == LAST_BYTE);
            sda_oe_d   = 1'b1;
            ack_hi_d   = 1'b0;
            state_d    = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_rise) begin
            ack_hi_d = 1'b1;
          end else if (scl_fall && ack_hi_q) begin
            ack_hi_d  = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q < 4'd8) begin
              sda_oe_d  = ~tx_q[31];
              tx_d      = {tx_q[30:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? 2'd0 : byte_cnt_q + 2'd1;
              if (byte_cnt_q == LAST_BYTE) begin
                tx_d     = Din;
                rd_req_d = 1'b1;
              end
              bit_cnt_d = 4'd0;
              state_d   = RD_DATA;
            end else begin
              stat_nack_d = 1'b1;
              busy_d      = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizers reset to the idle-bus level so a reset never fakes an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      scl_sync_q   <= 3'b111;
      sda_sync_q   <= 3'b111;
      bit_cnt_q    <= 4'd0;
      byte_cnt_q   <= 2'd0;
      rx_q         <= 8'd0;
      tx_q         <= 32'd0;
      dout_q       <= 32'd0;
      sda_oe_q     <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      stat_rw_q    <= 1'b0;
      stat_nack_q  <= 1'b0;
      stat_match_q <= 1'b0;
      ack_hi_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      dout_q       <= dout_d;
      sda_oe_q     <= sda_oe_d;
      wr_valid_q   <= wr_valid_d;
      rd_req_q     <= rd_req_d;
      busy_q       <= busy_d;
      stat_rw_q    <= stat_rw_d;
      stat_nack_q  <= stat_nack_d;
      stat_match_q <= stat_match_d;
      ack_hi_q     <= ack_hi_d;
    end
  end

  assign i2c_sda_oe = sda_oe_q;
  assign Dout       = dout_q;
  assign wr_valid   = wr_valid_q;
  assign rd_req     = rd_req_q;
  assign i2c_stat   = {2'b00, byte_cnt_q, stat_match_q, stat_nack_q, stat_rw_q, busy_q};

endmodule
